// File: rtl/cdbus_bus_fabric_if.sv
// cdbus_bus_fabric_if: per-node line bundle between cdbus nodes and the fabric.
// Ports: tx/tx_en driven by nodes, rx returned by the fabric.
interface cdbus_bus_fabric_if #(
  parameter int N_NODES = 3
);
  logic [N_NODES-1:0] tx;
  logic [N_NODES-1:0] tx_en;
  logic [N_NODES-1:0] rx;

  modport master (
    output tx,
    output tx_en,
    input  rx
  );

  modport slave (
    input  tx,
    input  tx_en,
    output rx
  );
endinterface

// File: rtl/cdbus_bus_fabric.sv
// cdbus_bus_fabric: cycle-accurate wired-AND / cross-connect bus model.
// Ports: clk, reset_n (sync, active low), bus (tx, tx_en, rx), force_low,
//   clr_cnt, bus_idle, collision, collision_cnt, active_cnt.
module cdbus_bus_fabric #(
  parameter int N_NODES     = 3,
  parameter int DELAY       = 2,
  parameter int FULL_DUPLEX = 0,
  parameter int IDLE_CYC    = 10,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  cdbus_bus_fabric_if.slave              bus,
  input  logic                           force_low,
  input  logic                           clr_cnt,
  output logic                           bus_idle,
  output logic                           collision,
  output logic [CNT_W-1:0]               collision_cnt,
  output logic [$clog2(N_NODES+1)-1:0]   active_cnt
);

  localparam int AW = $clog2(N_NODES + 1);

  typedef logic [N_NODES-1:0] vec_t;

  if (N_NODES < 2 || N_NODES > 16) begin : g_err_n
    $error("N_NODES must be 2..16");
  end
  if (FULL_DUPLEX != 0 && N_NODES < 2) begin : g_err_fd
    $error("full duplex needs at least 2 nodes");
  end
  if (DELAY < 0 || DELAY > 15) begin : g_err_d
    $error("DELAY must be 0..15");
  end
  if (IDLE_CYC < 1 || IDLE_CYC > 255) begin : g_err_i
    $error("IDLE_CYC must be 1..255");
  end

  logic lvl;
  logic no_en;
  logic has0;
  logic has1;
  logic idle_ok;
  logic coll_nx;
  vec_t src;

  assign no_en = (bus.tx_en == '0);
  assign lvl   = ~force_low & (&(bus.tx | ~bus.tx_en));
  assign has0  = |(bus.tx_en & ~bus.tx);
  assign has1  = |(bus.tx_en & bus.tx);
  assign coll_nx = (FULL_DUPLEX == 0) & has0 & has1;

  // Full duplex judges idleness purely on driver enables.
  assign idle_ok = (FULL_DUPLEX != 0) ? no_en : (lvl & no_en);

  if (FULL_DUPLEX != 0) begin : g_fd
    vec_t xsrc;
    for (genvar g = 0; g < N_NODES; g++) begin : g_x
      if ((g ^ 1) < N_NODES) begin : g_pair
        assign xsrc[g] = bus.tx[g^1];
      end else begin : g_odd
        assign xsrc[g] = 1'b1;
      end
    end
    assign src = force_low ? '0 : xsrc;
  end else begin : g_hd
    assign src = {N_NODES{lvl}};
  end

  if (DELAY == 0) begin : g_comb
    assign bus.rx = reset_n ? src : '1;
  end else begin : g_dl
    vec_t dl [DELAY];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 0; k < DELAY; k++)
          dl[k] <= '1;
      end else begin
        dl[0] <= src;
        for (int k = 1; k < DELAY; k++)
          dl[k] <= dl[k-1];
      end
    end
    assign bus.rx = dl[DELAY-1];
  end

  logic [7:0] idle_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_q   <= '0;
      bus_idle <= 1'b0;
    end else begin
      if (!idle_ok)
        idle_q <= '0;
      else if (idle_q != 8'(IDLE_CYC))
        idle_q <= idle_q + 8'd1;
      bus_idle <= idle_ok & (idle_q == 8'(IDLE_CYC));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
      active_cnt    <= '0;
    end else begin
      collision  <= coll_nx;
      active_cnt <= AW'($countones(bus.tx_en));
      // Clear wins, but a pulse in the same cycle still counts once.
      if (clr_cnt)
        collision_cnt <= CNT_W'(collision);
      else if (collision && collision_cnt != '1)
        collision_cnt <= collision_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdbus_bus_fabric.sv
// tb_cdbus_bus_fabric: scoreboard bench for three fabric configurations.
// Ports: none; drives HD delay-2, HD delay-0 and FD delay-2 instances.
module tb_cdbus_bus_fabric;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rstn, fl, clr;
  logic [2:0] tx, en;

  always #5 clk = ~clk;

  cdbus_bus_fabric_if #(.N_NODES(N)) b0 ();
  cdbus_bus_fabric_if #(.N_NODES(N)) b1 ();
  cdbus_bus_fabric_if #(.N_NODES(N)) b2 ();

  assign b0.tx = tx;
  assign b0.tx_en = en;
  assign b1.tx = tx;
  assign b1.tx_en = en;
  assign b2.tx = tx;
  assign b2.tx_en = en;

  logic [2:0] bi, co;
  logic [3:0] cc [3];
  logic [1:0] ac [3];
  logic [2:0] arx [3];

  assign arx[0] = b0.rx;
  assign arx[1] = b1.rx;
  assign arx[2] = b2.rx;

  cdbus_bus_fabric #(
    .N_NODES(N), .DELAY(2), .FULL_DUPLEX(0),
    .IDLE_CYC(10), .CNT_W(4)
  ) u_hd (
    .clk(clk), .reset_n(rstn), .bus(b0),
    .force_low(fl), .clr_cnt(clr),
    .bus_idle(bi[0]), .collision(co[0]),
    .collision_cnt(cc[0]), .active_cnt(ac[0])
  );

  cdbus_bus_fabric #(
    .N_NODES(N), .DELAY(0), .FULL_DUPLEX(0),
    .IDLE_CYC(10), .CNT_W(4)
  ) u_h0 (
    .clk(clk), .reset_n(rstn), .bus(b1),
    .force_low(fl), .clr_cnt(clr),
    .bus_idle(bi[1]), .collision(co[1]),
    .collision_cnt(cc[1]), .active_cnt(ac[1])
  );

  cdbus_bus_fabric #(
    .N_NODES(N), .DELAY(2), .FULL_DUPLEX(1),
    .IDLE_CYC(10), .CNT_W(4)
  ) u_fd (
    .clk(clk), .reset_n(rstn), .bus(b2),
    .force_low(fl), .clr_cnt(clr),
    .bus_idle(bi[2]), .collision(co[2]),
    .collision_cnt(cc[2]), .active_cnt(ac[2])
  );

  typedef struct packed {
    logic [2:0] rx;
    logic       idle;
    logic       coll;
    logic [3:0] cnt;
    logic [1:0] act;
  } exp_t;
  typedef exp_t [2:0] trio_t;

  trio_t sbq [$];

  int dly [3] = '{2, 0, 2};
  bit fdx [3] = '{0, 0, 1};

  logic [2:0] hist [3][16];
  int  run [3];
  int  ccnt [3];
  bit  mcoll [3];
  int  mact [3];

  int n_chk = 0;
  int n_fail = 0;
  bit running = 0;

  function automatic logic [2:0] src_of(int d);
    logic l;
    if (fdx[d]) begin
      if (fl) return 3'b000;
      return {1'b1, tx[0], tx[1]};
    end
    l = !fl;
    for (int i = 0; i < 3; i++)
      if (en[i] && !tx[i]) l = 1'b0;
    return {3{l}};
  endfunction

  task automatic edge_update();
    for (int d = 0; d < 3; d++) begin
      logic [2:0] s;
      bit ok, z, o;
      int p;
      s = src_of(d);
      if (!rstn) begin
        for (int k = 0; k < 16; k++) hist[d][k] = 3'b111;
        run[d] = 0;
        ccnt[d] = 0;
        mcoll[d] = 0;
        mact[d] = 0;
      end else begin
        if (clr) ccnt[d] = mcoll[d] ? 1 : 0;
        else if (mcoll[d] && ccnt[d] < 15) ccnt[d]++;
        z = 0;
        o = 0;
        p = 0;
        for (int i = 0; i < 3; i++) begin
          if (en[i]) begin
            p++;
            if (tx[i]) o = 1;
            else z = 1;
          end
        end
        mcoll[d] = !fdx[d] && z && o;
        mact[d] = p;
        ok = (en == 3'b000) && (fdx[d] || s[0]);
        run[d] = ok ? ((run[d] < 1000) ? run[d] + 1 : run[d]) : 0;
        for (int k = 15; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = s;
      end
    end
  endtask

  task automatic cyc(input logic [2:0] t, input logic [2:0] e,
                     input logic f, input logic c, input logic r);
    trio_t x;
    @(posedge clk);
    edge_update();
    #1;
    tx = t;
    en = e;
    fl = f;
    clr = c;
    rstn = r;
    for (int d = 0; d < 3; d++) begin
      if (dly[d] == 0) x[d].rx = rstn ? src_of(d) : 3'b111;
      else x[d].rx = hist[d][dly[d]-1];
      x[d].idle = (run[d] >= 11);
      x[d].coll = mcoll[d];
      x[d].cnt = 4'(ccnt[d]);
      x[d].act = 2'(mact[d]);
    end
    sbq.push_back(x);
    running = 1;
  endtask

  task automatic chk(input string nm, input int d,
                     input logic [3:0] a, input logic [3:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h want %h", nm, d, $time, a, e);
    end
  endtask

  initial begin
    trio_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        if (running) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty at %0t: got 0 entries want 1", $time);
        end
      end else begin
        x = sbq.pop_front();
        for (int d = 0; d < 3; d++) begin
          chk("rx", d, {1'b0, arx[d]}, {1'b0, x[d].rx});
          chk("bus_idle", d, {3'b0, bi[d]}, {3'b0, x[d].idle});
          chk("collision", d, {3'b0, co[d]}, {3'b0, x[d].coll});
          chk("collision_cnt", d, cc[d], x[d].cnt);
          chk("active_cnt", d, {2'b0, ac[d]}, {2'b0, x[d].act});
        end
      end
    end
  end

  initial begin
    int mode;
    logic [2:0] t, e;
    logic f, c, r;
    rstn = 0;
    tx = 3'b000;
    en = 3'b111;
    fl = 0;
    clr = 0;
    repeat (3) cyc(3'b000, 3'b111, 0, 0, 0);
    cyc(3'b001, 3'b001, 0, 0, 1);
    cyc(3'b000, 3'b001, 0, 0, 1);
    cyc(3'b001, 3'b001, 0, 0, 1);
    cyc(3'b001, 3'b001, 0, 0, 1);
    cyc(3'b000, 3'b001, 0, 0, 1);
    repeat (3) cyc(3'b010, 3'b011, 0, 0, 1);
    cyc(3'b010, 3'b011, 0, 1, 1);
    cyc(3'b000, 3'b000, 0, 0, 1);
    repeat (20) cyc(3'b010, 3'b011, 0, 0, 1);
    repeat (15) cyc($urandom, 3'b000, 0, 0, 1);
    cyc(3'b111, 3'b000, 1, 0, 1);
    repeat (14) cyc(3'b111, 3'b000, 0, 0, 1);
    cyc(3'b010, 3'b011, 0, 0, 1);
    cyc(3'b010, 3'b011, 0, 0, 0);
    cyc(3'b010, 3'b011, 0, 0, 1);
    mode = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 30 == 0) mode = $urandom_range(0, 3);
      t = 3'($urandom);
      f = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 299) != 0);
      case (mode)
        0: e = 3'($urandom);
        1: begin
          e = 3'b000;
          f = ($urandom_range(0, 59) == 0);
        end
        2: e = 3'b011;
        default: e = 3'(1 << $urandom_range(0, 2));
      endcase
      cyc(t, e, f, c, r);
    end
    running = 0;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
